// File: rtl/irrigation_valve_sequencer.sv
// Sprinkler/drip valve sequencer with water-supply lockout, changeover dead time and
// optional minimum-open hold (enabled by defining IRRIGATION_MIN_ON_EN).
module irrigation_valve_sequencer #(
  parameter int MIN_ON_CYCLES = 16,
  parameter int DEAD_CYCLES   = 8,
  parameter int FAULT_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soil_dry,
  input  logic       splinker_mode_on,
  input  logic       level_low,
  input  logic       level_mid,
  input  logic       level_high,
  output logic       splinker_valve,
  output logic       drip_valve,
  output logic       critical_alarm,
  output logic       sensor_fault,
  output logic [2:0] state
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int FLT_W  = $clog2(FAULT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPRINKLE = 3'd1,
    DRIP     = 3'd2,
    SWITCH   = 3'd3,
    LOCKOUT  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                target_q, target_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic [FLT_W-1:0]    fault_cnt_q, fault_cnt_d;
  logic                spl_q, drip_q, crit_q;
  logic                hazard, inconsistent, exit_ok, dead_done;

`ifdef IRRIGATION_MIN_ON_EN
  localparam int ON_W = $clog2(MIN_ON_CYCLES + 1);
  logic [ON_W-1:0]     on_cnt_q, on_cnt_d;
  assign exit_ok = (on_cnt_q == ON_W'(MIN_ON_CYCLES - 1));
`else
  assign exit_ok = 1'b1;
`endif

  assign inconsistent = (level_high & ~level_mid) | (level_mid & ~level_low);
  assign sensor_fault = (fault_cnt_q == FLT_W'(FAULT_CYCLES));
  assign hazard       = ~level_low | sensor_fault;
  assign dead_done    = (dead_cnt_q == DEAD_W'(DEAD_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (hazard) begin
      state_d = LOCKOUT;
    end else begin
      case (state_q)
        IDLE: begin
          if (soil_dry) state_d = splinker_mode_on ? SPRINKLE : DRIP;
        end
        SPRINKLE: begin
          if (exit_ok) begin
            if (!soil_dry) begin
              state_d = IDLE;
            end else if (!splinker_mode_on) begin
              state_d  = SWITCH;
              target_d = 1'b0;
            end
          end
        end
        DRIP: begin
          if (exit_ok) begin
            if (!soil_dry) begin
              state_d = IDLE;
            end else if (splinker_mode_on) begin
              state_d  = SWITCH;
              target_d = 1'b1;
            end
          end
        end
        SWITCH: begin
          // Target was latched on entry; mode changes here are deliberately ignored.
          if (dead_done) state_d = !soil_dry ? IDLE : (target_q ? SPRINKLE : DRIP);
        end
        LOCKOUT: begin
          if (dead_done) state_d = IDLE;
        end
        default: state_d = LOCKOUT;
      endcase
    end
  end

  always_comb begin
    dead_cnt_d = '0;
    if ((state_q == SWITCH || state_q == LOCKOUT) && state_d == state_q && !hazard) begin
      dead_cnt_d = dead_done ? dead_cnt_q : dead_cnt_q + DEAD_W'(1);
    end
    fault_cnt_d = '0;
    if (inconsistent) begin
      fault_cnt_d = sensor_fault ? fault_cnt_q : fault_cnt_q + FLT_W'(1);
    end
  end

`ifdef IRRIGATION_MIN_ON_EN
  always_comb begin
    on_cnt_d = '0;
    if (state_d == state_q && (state_q == SPRINKLE || state_q == DRIP)) begin
      on_cnt_d = exit_ok ? on_cnt_q : on_cnt_q + ON_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) on_cnt_q <= '0;
    else        on_cnt_q <= on_cnt_d;
  end
`endif

  // Valves are loaded from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_q    <= 1'b0;
      dead_cnt_q  <= '0;
      fault_cnt_q <= '0;
      spl_q       <= 1'b0;
      drip_q      <= 1'b0;
      crit_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      dead_cnt_q  <= dead_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      spl_q       <= (state_d == SPRINKLE);
      drip_q      <= (state_d == DRIP);
      crit_q      <= ~level_low;
    end
  end

  assign splinker_valve = spl_q;
  assign drip_valve     = drip_q;
  assign critical_alarm = crit_q;
  assign state          = state_q;

endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// Table-driven scoreboard bench for irrigation_valve_sequencer; expectations follow
// IRRIGATION_MIN_ON_EN (minimum-on hold length collapses to 1 cycle when undefined).
module tb_irrigation_valve_sequencer;

  localparam int MIN_ON = 16;
  localparam int DEAD   = 8;
  localparam int FAULT  = 4;
`ifdef IRRIGATION_MIN_ON_EN
  localparam int MO = MIN_ON;
`else
  localparam int MO = 1;
`endif

  // Expected output vector: {splinker_valve, drip_valve, critical_alarm, sensor_fault, state}
  localparam logic [6:0] X_IDLE = 7'b0000000;
  localparam logic [6:0] X_SPR  = 7'b1000001;
  localparam logic [6:0] X_SPRF = 7'b1001001;
  localparam logic [6:0] X_DRP  = 7'b0100010;
  localparam logic [6:0] X_SW   = 7'b0000011;
  localparam logic [6:0] X_LK   = 7'b0000100;
  localparam logic [6:0] X_LKC  = 7'b0010100;
  localparam logic [6:0] X_LKF  = 7'b0001100;

  typedef struct packed {
    logic [4:0] in;   // {soil_dry, mode, level_low, level_mid, level_high}
    logic [6:0] ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic soil_dry = 1'b0, splinker_mode_on = 1'b0;
  logic level_low = 1'b0, level_mid = 1'b0, level_high = 1'b0;
  logic splinker_valve, drip_valve, critical_alarm, sensor_fault;
  logic [2:0] state;

  vec_t       tbl[$];
  logic [6:0] sb[$];
  int         errors = 0;
  int         checks = 0;

  irrigation_valve_sequencer #(
    .MIN_ON_CYCLES(MIN_ON),
    .DEAD_CYCLES  (DEAD),
    .FAULT_CYCLES (FAULT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .soil_dry        (soil_dry),
    .splinker_mode_on(splinker_mode_on),
    .level_low       (level_low),
    .level_mid       (level_mid),
    .level_high      (level_high),
    .splinker_valve  (splinker_valve),
    .drip_valve      (drip_valve),
    .critical_alarm  (critical_alarm),
    .sensor_fault    (sensor_fault),
    .state           (state)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ok(input logic sd, input logic md);
    return {sd, md, 3'b111};
  endfunction

  function automatic logic [6:0] outs();
    return {splinker_valve, drip_valve, critical_alarm, sensor_fault, state};
  endfunction

  task automatic add(input int n, input logic [4:0] in, input logic [6:0] ex);
    vec_t v;
    v.in = in;
    v.ex = ex;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic drive(input logic [4:0] in);
    {soil_dry, splinker_mode_on, level_low, level_mid, level_high} = in;
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {spl,drip,crit,flt,st}=%b required %b", name, got, exp);
    end
  endtask

  initial begin
    // sprinkler on demand, soil_dry dropped at cycle 3, held until min-on elapses
    add(2, ok(1, 1), X_SPR);
    add((MO > 2) ? MO - 2 : 0, ok(0, 1), X_SPR);
    add(1, ok(0, 1), X_IDLE);
    // changeover sprinkler -> drip with dead time; mode flips during SWITCH ignored
    add(MO, ok(1, 1), X_SPR);
    add(1, ok(1, 0), X_SW);
    add(DEAD - 1, ok(1, 1), X_SW);
    add(1, ok(1, 0), X_DRP);
    // critical level in DRIP, recovery with a hazard that restarts the clean count
    add(1, ok(1, 0), X_DRP);
    add(1, 5'b10000, X_LKC);
    add(3, ok(0, 0), X_LK);
    add(1, 5'b00000, X_LKC);
    add(DEAD - 1, ok(0, 0), X_LK);
    add(1, ok(0, 0), X_IDLE);
    // hazard wins over demand in IDLE
    add(1, 5'b11000, X_LKC);
    add(DEAD - 1, ok(0, 0), X_LK);
    add(1, ok(0, 0), X_IDLE);
    // !soil_dry together with a mode change exits to IDLE
    add(MO, ok(1, 1), X_SPR);
    add(1, ok(0, 0), X_IDLE);
    // short demand pulse: 1-cycle valve when min-on is disabled
    add(1, ok(1, 0), X_DRP);
    add(MO - 1, ok(0, 0), X_DRP);
    add(1, ok(0, 0), X_IDLE);
    // sensor fault: 3 inconsistent cycles are forgiven, 4 confirm the fault
    add(1, ok(1, 1), X_SPR);
    add(3, 5'b11101, X_SPR);
    add(1, ok(1, 1), X_SPR);
    add(3, 5'b11101, X_SPR);
    add(1, 5'b11101, X_SPRF);
    add(1, 5'b01101, X_LKF);
    add(1, ok(0, 1), X_LK);
    add(DEAD - 1, ok(0, 1), X_LK);
    add(1, ok(0, 1), X_IDLE);

    drive(5'b00000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), X_IDLE);

    @(negedge clk);
    drive(ok(0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].in);
      sb.push_back(tbl[i].ex);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("sb_underflow", outs(), 7'bxxxxxxx);
      end else begin
        check($sformatf("row%0d", i), outs(), sb.pop_front());
      end
    end

    // asynchronous reset while the sprinkler is open
    @(negedge clk);
    drive(ok(1, 1));
    @(posedge clk);
    #1;
    check("async_pre_open", outs(), X_SPR);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_closes", outs(), X_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    drive(ok(1, 0));
    sb.push_back(X_DRP);
    @(posedge clk);
    #1;
    check("post_reset_from_idle", outs(), sb.pop_front());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irrigation_valve_sequencer.md
# irrigation_valve_sequencer

Sequential valve controller directly downstream of the irrigation mode selector. It consumes the selector's `splinker_mode_on` decision, the soil-moisture demand and the raw water-supply level sensors, and drives the sprinkler and drip valves. It enforces the water-supply safety rules: close everything on a critical level or a sensor fault. It also enforces a dead time between valve changeovers and a minimum valve-open time.

## Interface

Parameters:
- `MIN_ON_CYCLES`, 16: minimum cycles a valve stays open once opened, ≥1.
- `DEAD_CYCLES`, 8: both-closed gap on changeover, and lockout clear time, ≥1.
- `FAULT_CYCLES`, 4: consecutive inconsistent-sensor cycles before a fault is confirmed, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `soil_dry` in 1: irrigation demand.
- `splinker_mode_on` in 1: 1 selects sprinkler, 0 selects drip; from the mode selector.
- `level_low` in 1: water above the critical mark.
- `level_mid` in 1: water above the middle mark.
- `level_high` in 1: water above the high mark.
- `splinker_valve` out 1: sprinkler valve open.
- `drip_valve` out 1: drip valve open.
- `critical_alarm` out 1: registered copy of `!level_low`.
- `sensor_fault` out 1: fault confirmed.
- `state` out 3: current FSM state.

## Operation

- Hazard conditions:
  - Critical = `!level_low`.
  - Inconsistent = `(level_high & !level_mid) | (level_mid & !level_low)`.
  - `fault_cnt` increments while inconsistent, saturating at `FAULT_CYCLES`, and clears to 0 on any consistent cycle.
  - `sensor_fault` = (`fault_cnt == FAULT_CYCLES`).
  - hazard = critical | `sensor_fault`.
- States: IDLE=0, SPRINKLE=1, DRIP=2, SWITCH=3, LOCKOUT=4. Codes 5–7 are illegal and go to LOCKOUT.
- Priority 1: from any state, hazard → LOCKOUT.
- IDLE: on `soil_dry`, go to SPRINKLE if `splinker_mode_on`, otherwise DRIP. No dead time applies from IDLE.
- SPRINKLE/DRIP:
  - `on_cnt` starts at 0 on entry and increments, saturating at `MIN_ON_CYCLES-1`.
  - Exit is allowed only when `on_cnt == MIN_ON_CYCLES-1`.
  - `!soil_dry` → IDLE.
  - `soil_dry` with the mode disagreeing with the current valve → SWITCH, latching the new target.
  - Otherwise hold.
- SWITCH:
  - Both valves closed; `dead_cnt` counts 0..`DEAD_CYCLES-1`.
  - At terminal count: go to the latched target if `soil_dry`, else IDLE.
  - Mode changes during SWITCH are ignored; the target stays latched.
- LOCKOUT:
  - Both valves closed; `dead_cnt` clears on every hazard cycle.
  - Goes to IDLE after `DEAD_CYCLES` consecutive hazard-free cycles.
- Valve outputs:
  - `splinker_valve` = (state==SPRINKLE); `drip_valve` = (state==DRIP).
  - Both are flops loaded from the next-state value, so they never glitch.
  - The two valves are never high in the same cycle.
- Counter widths are `$clog2(param+1)`; counters never wrap.

## Timing

- Reset value of every output and register is 0: state IDLE, valves closed, `critical_alarm` 0, `sensor_fault` 0, all counters 0.
- Reset is asynchronous mid-operation: valves close immediately and the next edge after deassertion evaluates from IDLE.
- Demand latency: `soil_dry` high before edge N gives the valve open after edge N, i.e. 1 cycle.
- Critical latency: `level_low` low before edge N gives valves closed and `critical_alarm` high after edge N, regardless of `on_cnt`.
- Fault latency: an inconsistent pattern held for cycles N..N+`FAULT_CYCLES`-1 sets `sensor_fault` after edge N+`FAULT_CYCLES`-1. Valves close on the following edge.
- Changeover: closed-to-open gap between the two valves is exactly `DEAD_CYCLES` cycles.
- Simultaneous events:
  - Hazard wins over demand or switch.
  - `!soil_dry` together with a mode change exits to IDLE, not SWITCH.

## Configuration

- `IRRIGATION_MIN_ON_EN` defined: minimum-on hold exactly as in Operation.
- `IRRIGATION_MIN_ON_EN` not defined:
  - `on_cnt` is removed and exit is allowed every cycle, so a valve can open for 1 cycle.
  - Dead time and all hazard behaviour are unchanged.

## Test plan

- Reset, then `soil_dry`=1, `splinker_mode_on`=1, all levels 1 → `splinker_valve`=1 after one edge; `soil_dry` dropped at cycle 3 → valve stays open until cycle 16, then state=0.
- In SPRINKLE with min-on elapsed, mode→0 → 8 cycles with both valves 0, then `drip_valve`=1.
- In DRIP at cycle 2, `level_low`=0 → valves 0 and `critical_alarm`=1 after the next edge, state=4. Level restored → state=0 after 8 clean cycles.
- `level_high`=1, `level_mid`=0 for 3 cycles then consistent → no fault. Held 4 cycles → `sensor_fault`=1, then LOCKOUT.
- Assert `rst_n`=0 asynchronously while a valve is open → both valves 0 before the next clock edge. With the macro undefined, a 1-cycle `soil_dry` pulse gives a 1-cycle valve pulse.
